scan_seq_4to16: RTL and testbench

- Upstream sequencer that feeds the 4-to-16 active-low decoder stage with the 4-bit select D[3:0] and enable En.
- Walks the enabled rows/lines of a 16-way scanned load (LED matrix rows, keypad columns) in ascending order with wrap-around.
- Each row is held for a programmable dwell time.
- Forced blanking (En=0) separates rows so D always settles before the decoder output is enabled.

---
 rtl/scan_seq_4to16_pkg.sv | 7 +
 rtl/scan_seq_4to16_if.sv | 13 +
 rtl/scan_seq_4to16_next_row_find.sv | 28 ++
 rtl/scan_seq_4to16.sv | 88 ++++++++
 tb/tb_scan_seq_4to16.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/scan_seq_4to16_pkg.sv
// Shared types and constants for the 16-row scan sequencer.
package scan_seq_4to16_pkg;
    localparam int ROWS  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;
endpackage

// File: rtl/scan_seq_4to16_if.sv
// Control/status bundle between the scan sequencer and its parent.
interface scan_seq_4to16_if #(parameter int DWELL_W = 8);
    logic               run;
    logic [DWELL_W-1:0] dwell;
    logic [15:0]        row_mask;
    logic [3:0]         D;
    logic               En;
    logic               frame_start;
    logic               busy;

    modport master (output run, dwell, row_mask, input D, En, frame_start, busy);
    modport slave  (input run, dwell, row_mask, output D, En, frame_start, busy);
endinterface

// File: rtl/scan_seq_4to16_next_row_find.sv
// Finds the first enabled row strictly above 'row', wrapping to the lowest one.
module next_row_find
    import scan_seq_4to16_pkg::*;
(
    input  logic [SEL_W-1:0] row,
    input  logic [ROWS-1:0]  mask,
    output logic [SEL_W-1:0] next,
    output logic             wrap,
    output logic             any_set
);
    logic [SEL_W:0]    shamt;
    logic [2*ROWS-1:0] dbl;
    logic [ROWS-1:0]   rot;
    logic [SEL_W-1:0]  off;

    // Rotate so bit 0 is the row after 'row'; a shift of ROWS yields the mask unchanged.
    always_comb begin
        shamt = {1'b0, row} + (SEL_W+1)'(1);
        dbl   = {mask, mask} >> shamt;
        rot   = dbl[ROWS-1:0];
        off   = '0;
        for (int i = ROWS-1; i >= 0; i--)
            if (rot[i]) off = SEL_W'(i);
        next    = row + off + SEL_W'(1);
        wrap    = (next <= row);
        any_set = |mask;
    end
endmodule

// File: rtl/scan_seq_4to16.sv
// Row scan sequencer: BLANK (En=0, D settles) then DRIVE (En=1) per enabled row.
module scan_seq_4to16
    import scan_seq_4to16_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input logic              clk,
    input logic              rst_n,
    scan_seq_4to16_if.slave  bus
);
    state_t             state;
    logic [3:0]         blank_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_load;
    logic [SEL_W-1:0]   find_row;
    logic [SEL_W-1:0]   nxt;
    logic               wrap;
    logic               any_set;

    // From IDLE, searching above row 15 returns the lowest enabled row.
    assign find_row   = (state == IDLE) ? SEL_W'(ROWS-1) : bus.D;
    assign dwell_load = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    next_row_find u_find (
        .row     (find_row),
        .mask    (bus.row_mask),
        .next    (nxt),
        .wrap    (wrap),
        .any_set (any_set)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.D           <= '0;
            bus.En          <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
            blank_cnt       <= '0;
            dwell_cnt       <= '0;
        end else begin
            bus.frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.run && any_set) begin
                        state           <= BLANK;
                        bus.D           <= nxt;
                        bus.frame_start <= 1'b1;
                        bus.busy        <= 1'b1;
                        blank_cnt       <= 4'(BLANK_CYC-1);
                        dwell_cnt       <= dwell_load;
                    end
                end
                BLANK: begin
                    if (blank_cnt == '0) begin
                        state  <= DRIVE;
                        bus.En <= 1'b1;
                    end else begin
                        blank_cnt <= blank_cnt - 4'd1;
                    end
                end
                DRIVE: begin
                    if (dwell_cnt == '0) begin
                        bus.En <= 1'b0;
                        if (bus.run && any_set) begin
                            state           <= BLANK;
                            bus.D           <= nxt;
                            bus.frame_start <= wrap;
                            blank_cnt       <= 4'(BLANK_CYC-1);
                            dwell_cnt       <= dwell_load;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.En   <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scan_seq_4to16.sv
// Directed bench for scan_seq_4to16 with BLANK_CYC=2, DWELL_W=8.
module tb_scan_seq_4to16;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    scan_seq_4to16_if #(.DWELL_W(8)) bus ();

    scan_seq_4to16 #(.DWELL_W(8), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [7:0]  dwell;
        logic [15:0] mask;
        logic [3:0]  d;
        logic        en;
        logic        fs;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic run, input logic [7:0] dwell, input logic [15:0] mask,
                                input logic [3:0] d, input logic en, input logic fs, input logic busy);
        vec_t v;
        v.run = run; v.dwell = dwell; v.mask = mask;
        v.d = d; v.en = en; v.fs = fs; v.busy = busy;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [3:0] d, input logic en,
                           input logic fs, input logic busy);
        chk({name, ".D"}, 32'(bus.D), 32'(d));
        chk({name, ".En"}, 32'(bus.En), 32'(en));
        chk({name, ".frame_start"}, 32'(bus.frame_start), 32'(fs));
        chk({name, ".busy"}, 32'(bus.busy), 32'(busy));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.run = 1'b0; bus.dwell = 8'd0; bus.row_mask = 16'h0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] prev_d;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.run = 1'b0; bus.dwell = 8'd0; bus.row_mask = 16'h0;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Table: two-row wrap, single-row repeat, run drop, empty mask, dwell=0.
        for (int i = 0; i < 3; i++) begin
            add(1, 1, 16'h8001, 0,  0, (i == 0) ? 1'b1 : 1'b1, 1);
            add(1, 1, 16'h8001, 0,  0, 0, 1);
            add(1, 1, 16'h8001, 0,  1, 0, 1);
            if (i == 2) break;
            add(1, 1, 16'h8001, 15, 0, 0, 1);
            add(1, 1, 16'h8001, 15, 0, 0, 1);
            add(1, 1, 16'h8001, 15, 1, 0, 1);
        end
        add(1, 1, 16'h8001, 15, 0, 0, 1);
        add(1, 1, 16'h8001, 15, 0, 0, 1);
        add(1, 1, 16'h8001, 15, 1, 0, 1);
        for (int k = 0; k < 2; k++) begin
            add(1, 3, 16'h0010, 4, 0, 1, 1);
            add(1, 3, 16'h0010, 4, 0, 0, 1);
            add(1, 3, 16'h0010, 4, 1, 0, 1);
            add(1, 3, 16'h0010, 4, 1, 0, 1);
            add(1, 3, 16'h0010, 4, 1, 0, 1);
        end
        add(1, 3, 16'h0010, 4, 0, 1, 1);
        add(0, 3, 16'h0010, 4, 0, 0, 1);
        add(0, 3, 16'h0010, 4, 1, 0, 1);
        add(0, 3, 16'h0010, 4, 1, 0, 1);
        add(0, 3, 16'h0010, 4, 1, 0, 1);
        add(0, 3, 16'h0010, 4, 0, 0, 0);
        add(0, 3, 16'h0010, 4, 0, 0, 0);
        add(1, 3, 16'h0000, 4, 0, 0, 0);
        add(1, 0, 16'h0004, 2, 0, 1, 1);
        add(1, 0, 16'h0004, 2, 0, 0, 1);
        add(1, 0, 16'h0004, 2, 1, 0, 1);
        add(1, 0, 16'h0004, 2, 0, 1, 1);
        add(1, 0, 16'h0004, 2, 0, 0, 1);
        add(1, 0, 16'h0004, 2, 1, 0, 1);
        add(1, 0, 16'h0004, 2, 0, 1, 1);

        foreach (vecs[i]) begin
            bus.run = vecs[i].run; bus.dwell = vecs[i].dwell; bus.row_mask = vecs[i].mask;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].d, vecs[i].en, vecs[i].fs, vecs[i].busy);
        end

        // Full mask, dwell=3: 5-cycle rows, 80-cycle frames, En low on every D change.
        do_reset();
        bus.run = 1'b1; bus.dwell = 8'd3; bus.row_mask = 16'hFFFF;
        prev_d = 4'd0;
        for (int t = 0; t < 200; t++) begin
            step();
            chk_out($sformatf("full_t%0d", t), 4'((t / 5) % 16), (t % 5) >= 2, (t % 80) == 0, 1'b1);
            if (bus.D !== prev_d) chk($sformatf("en_on_dchange_t%0d", t), 32'(bus.En), 32'd0);
            prev_d = bus.D;
        end

        // run dropped in DRIVE cycle 2 with dwell=5: row completes then IDLE.
        do_reset();
        bus.run = 1'b1; bus.dwell = 8'd5; bus.row_mask = 16'h0008;
        step(); chk_out("drop_b0", 4'd3, 1'b0, 1'b1, 1'b1);
        step(); chk_out("drop_b1", 4'd3, 1'b0, 1'b0, 1'b1);
        step(); chk_out("drop_d1", 4'd3, 1'b1, 1'b0, 1'b1);
        step(); chk_out("drop_d2", 4'd3, 1'b1, 1'b0, 1'b1);
        bus.run = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            step(); chk_out($sformatf("drop_d%0d", k), 4'd3, 1'b1, 1'b0, 1'b1);
        end
        step(); chk_out("drop_idle0", 4'd3, 1'b0, 1'b0, 1'b0);
        step(); chk_out("drop_idle1", 4'd3, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges in DRIVE.
        do_reset();
        bus.run = 1'b1; bus.dwell = 8'd5; bus.row_mask = 16'h0040;
        step(); step(); step();
        chk_out("arst_pre", 4'd6, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_out("arst_now", 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; bus.row_mask = 16'h0030;
        step(); chk_out("arst_restart", 4'd4, 1'b0, 1'b1, 1'b1);

        // Mask FFFF -> 00F0 while row 2 drives: row 2 finishes, then row 4.
        do_reset();
        bus.run = 1'b1; bus.dwell = 8'd3; bus.row_mask = 16'hFFFF;
        for (int t = 0; t < 13; t++) step();
        chk_out("mask_d2", 4'd2, 1'b1, 1'b0, 1'b1);
        bus.row_mask = 16'h00F0;
        step(); chk_out("mask_d2b", 4'd2, 1'b1, 1'b0, 1'b1);
        step(); chk_out("mask_d2c", 4'd2, 1'b1, 1'b0, 1'b1);
        step(); chk_out("mask_r4b0", 4'd4, 1'b0, 1'b0, 1'b1);
        step(); chk_out("mask_r4b1", 4'd4, 1'b0, 1'b0, 1'b1);
        step(); chk_out("mask_r4d", 4'd4, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
